// File: rtl/fir_deconv8.sv
// fir_deconv8 -- inverse stage of the 4-tap FIR y[n] = 4x[n] + 3x[n-1] + 2x[n-2] + x[n-3].
//
// Recovers the original DW-bit samples from full-precision filtered samples by
// subtracting the contribution of the three previously recovered samples and
// dividing by the leading tap (4). Out-of-range or non-integral results are
// saturated and flagged.
//
// Ports:
//   CLK         rising-edge clock
//   reset       synchronous, active-high reset
//   y_valid     y_data is valid
//   y_ready     block accepts y_data this cycle
//   y_data      unsigned filtered sample (YW bits)
//   x_valid     x_data is valid
//   x_ready     downstream accepts x_data
//   x_data      recovered sample (DW bits)
//   clr_err     clears err_sticky
//   err         error flag travelling with the offending x_data
//   err_sticky  latched error, set wins over clr_err
//   sample_cnt  count of emitted samples (wraps)
module fir_deconv8 #(
    parameter int DW = 8,
    parameter int YW = 12,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          y_valid,
    output logic          y_ready,
    input  logic [YW-1:0] y_data,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [DW-1:0] x_data,
    input  logic          clr_err,
    output logic          err,
    output logic          err_sticky,
    output logic [CW-1:0] sample_cnt
);

    // Residual width: enough headroom that y - 6*max(x) never wraps.
    localparam int RW = YW + 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic          accept;
    logic          transfer;

    logic [DW-1:0] h1;
    logic [DW-1:0] h2;
    logic [DW-1:0] h3;

    logic [RW-1:0]        y_ext;
    logic [RW-1:0]        h1_ext;
    logic [RW-1:0]        h2_ext;
    logic [RW-1:0]        h3_ext;
    logic [RW-1:0]        r;
    logic signed [RW-1:0] q;
    logic [DW-1:0]        x_out;
    logic                 x_err;

    assign accept   = y_valid && y_ready;
    assign transfer = x_valid && x_ready;

    // ------------------------------------------------------------------
    // Output-stage FSM: state register
    // ------------------------------------------------------------------
    // NOTE: state elements use non-blocking assignments so every register
    // samples the pre-edge values of all others, independent of block order.
    always_ff @(posedge CLK) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Next-state logic
    // NOTE: every signal driven here gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (transfer && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // Output logic; reset forces y_ready low so nothing is accepted mid-reset.
    always_comb begin
        x_valid = (state == FULL);
        y_ready = !reset && ((state == EMPTY) || x_ready);
    end

    // ------------------------------------------------------------------
    // Residual, scaling and saturation
    // ------------------------------------------------------------------
    always_comb begin
        y_ext  = RW'(y_data);
        h1_ext = RW'(h1);
        h2_ext = RW'(h2);
        h3_ext = RW'(h3);
        // Modular RW-bit arithmetic; the result is read as two's complement.
        r      = y_ext - (h1_ext << 1) - h1_ext - (h2_ext << 1) - h3_ext;
        q      = $signed(r) >>> 2;
        x_out  = q[DW-1:0];
        x_err  = (r[1:0] != 2'b00);
        if (r[RW-1]) begin
            x_out = '0;
            x_err = 1'b1;
        end else if (q[RW-1:DW] != '0) begin
            x_out = '1;
            x_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            x_data     <= '0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            sample_cnt <= '0;
            h1         <= '0;
            h2         <= '0;
            h3         <= '0;
        end else begin
            if (accept) begin
                x_data <= x_out;
                err    <= x_err;
                // History follows the emitted (saturated) value so the inverse
                // stays in lock-step with what downstream actually saw.
                h3     <= h2;
                h2     <= h1;
                h1     <= x_out;
            end else if (transfer) begin
                err <= 1'b0;
            end

            if (transfer) sample_cnt <= sample_cnt + 1'b1;

            if (accept && x_err) err_sticky <= 1'b1;
            else if (clr_err)    err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_deconv8.sv
// Self-checking bench for fir_deconv8: directed scenarios plus a random
// stream generated through the forward FIR, with a scoreboard of expected
// output samples checked at every output transfer.
module tb_fir_deconv8;

    logic        CLK = 1'b0;
    logic        reset;
    logic        y_valid;
    logic        y_ready;
    logic [11:0] y_data;
    logic        x_valid;
    logic        x_ready;
    logic [7:0]  x_data;
    logic        clr_err;
    logic        err;
    logic        err_sticky;
    logic [15:0] sample_cnt;

    typedef struct {
        logic [7:0] x;
        logic       e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   rand_bp = 1'b0;

    fir_deconv8 #(.DW(8), .YW(12), .CW(16)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .clr_err    (clr_err),
        .err        (err),
        .err_sticky (err_sticky),
        .sample_cnt (sample_cnt)
    );

    always #5 CLK = ~CLK;

    // Random backpressure, changed just after each rising edge.
    always @(posedge CLK) begin
        if (rand_bp) begin
            #1;
            x_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: every transfer pops and checks one expected sample.
    always @(negedge CLK) begin
        if (reset === 1'b0 && x_valid === 1'b1 && x_ready === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got x_data=%0d err=%0b, expected no output", x_data, err);
            end else begin
                mon_e = sb.pop_front();
                if (x_data !== mon_e.x || err !== mon_e.e) begin
                    bad++;
                    $display("FAIL out_sample: got x_data=%0d err=%0b, expected x_data=%0d err=%0b",
                             x_data, err, mon_e.x, mon_e.e);
                end
            end
        end
    end

    task automatic do_reset();
        rand_bp = 1'b0;
        reset   = 1'b1;
        y_valid = 1'b0;
        y_data  = '0;
        clr_err = 1'b0;
        x_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    // Offer one y sample, queue its expected output, return just after accept.
    task automatic send(input logic [11:0] y, input logic [7:0] ex, input logic ee);
        int n;
        exp_t e;
        e.x = ex;
        e.e = ee;
        sb.push_back(e);
        y_valid = 1'b1;
        y_data  = y;
        n = 0;
        @(negedge CLK);
        while (y_ready !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: y_ready=%0b, expected 1 within 200 cycles", y_ready);
        end
        @(posedge CLK);
        #1;
        y_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        y_valid = 1'b1;
        y_data  = 12'd40;
        x_ready = 1'b1;
        clr_err = 1'b0;
        @(negedge CLK);
        total++;
        if (y_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_y_ready: got %0b, expected 0", y_ready);
        end
        do_reset();
        @(negedge CLK);
        total++;
        if (x_valid !== 1'b0 || x_data !== 8'd0 || err !== 1'b0 || err_sticky !== 1'b0 || sample_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: got x_valid=%0b x_data=%0d err=%0b sticky=%0b cnt=%0d, expected all 0",
                     x_valid, x_data, err, err_sticky, sample_cnt);
        end
        total++;
        if (y_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_after: got %0b, expected 1", y_ready);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_stream();
        do_reset();
        send(12'd40, 8'd10, 1'b0);
        total++;
        if (x_valid !== 1'b1 || x_data !== 8'd10) begin
            bad++;
            $display("FAIL stream_latency: got x_valid=%0b x_data=%0d, expected 1/10", x_valid, x_data);
        end
        send(12'd110, 8'd20, 1'b0);
        total++;
        if (x_valid !== 1'b1 || x_data !== 8'd20) begin
            bad++;
            $display("FAIL stream_back_to_back: got x_valid=%0b x_data=%0d, expected 1/20", x_valid, x_data);
        end
        send(12'd200, 8'd30, 1'b0);
        @(posedge CLK);
        #1;
        total++;
        if (sample_cnt !== 16'd3 || x_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_count: got cnt=%0d x_valid=%0b, expected 3/0", sample_cnt, x_valid);
        end
        drain("stream");
    endtask

    task automatic test_error();
        do_reset();
        send(12'd42, 8'd10, 1'b0 | 1'b1);
        total++;
        if (err !== 1'b1 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_set: got err=%0b sticky=%0b, expected 1/1", err, err_sticky);
        end
        @(posedge CLK);
        #1;
        clr_err = 1'b1;
        @(posedge CLK);
        #1;
        clr_err = 1'b0;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got sticky=%0b, expected 0", err_sticky);
        end
        // h1=10: r = 43 - 30 = 13 -> x=3 with remainder; clear in the same cycle loses.
        clr_err = 1'b1;
        send(12'd43, 8'd3, 1'b1);
        clr_err = 1'b0;
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_set_wins: got sticky=%0b, expected 1", err_sticky);
        end
        drain("error");
    endtask

    task automatic test_sat_low();
        do_reset();
        send(12'd4, 8'd1, 1'b0);
        send(12'd0, 8'd0, 1'b1);
        // History now h1=0, h2=1, h3=0: 4*5 + 2*1 = 22 recovers 5 cleanly.
        send(12'd22, 8'd5, 1'b0);
        drain("sat_low");
    endtask

    task automatic test_sat_high();
        do_reset();
        send(12'd1024, 8'd255, 1'b1);
        send(12'd1020, 8'd63, 1'b1);
        drain("sat_high");
    endtask

    task automatic test_backpressure();
        exp_t e;
        do_reset();
        send(12'd40, 8'd10, 1'b0);
        x_ready = 1'b0;
        e.x = 8'd20;
        e.e = 1'b0;
        sb.push_back(e);
        y_valid = 1'b1;
        y_data  = 12'd110;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            total++;
            if (y_ready !== 1'b0 || x_valid !== 1'b1 || x_data !== 8'd10) begin
                bad++;
                $display("FAIL bp_hold_%0d: got y_ready=%0b x_valid=%0b x_data=%0d, expected 0/1/10",
                         i, y_ready, x_valid, x_data);
            end
        end
        @(posedge CLK);
        #1;
        x_ready = 1'b1;
        @(posedge CLK);
        #1;
        y_valid = 1'b0;
        total++;
        if (x_valid !== 1'b1 || x_data !== 8'd20) begin
            bad++;
            $display("FAIL bp_release: got x_valid=%0b x_data=%0d, expected 1/20", x_valid, x_data);
        end
        send(12'd200, 8'd30, 1'b0);
        @(posedge CLK);
        #1;
        total++;
        if (sample_cnt !== 16'd3) begin
            bad++;
            $display("FAIL bp_count: got cnt=%0d, expected 3", sample_cnt);
        end
        drain("bp");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(12'd42, 8'd10, 1'b1);
        @(posedge CLK);
        #1;
        x_ready = 1'b0;
        send(12'd110, 8'd20, 1'b0);
        total++;
        if (x_valid !== 1'b1 || sample_cnt !== 16'd1 || err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got x_valid=%0b cnt=%0d sticky=%0b, expected 1/1/1",
                     x_valid, sample_cnt, err_sticky);
        end
        reset   = 1'b1;
        x_ready = 1'b1;
        y_valid = 1'b1;
        y_data  = 12'd110;
        @(negedge CLK);
        total++;
        if (y_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_y_ready: got %0b, expected 0", y_ready);
        end
        @(posedge CLK);
        #1;
        reset   = 1'b0;
        y_valid = 1'b0;
        sb.delete();
        total++;
        if (x_valid !== 1'b0 || sample_cnt !== 16'd0 || err_sticky !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_post: got x_valid=%0b cnt=%0d sticky=%0b err=%0b, expected all 0",
                     x_valid, sample_cnt, err_sticky, err);
        end
        send(12'd40, 8'd10, 1'b0);
        drain("mid");
    endtask

    // Random samples pushed through the forward FIR must come back exactly.
    task automatic test_random();
        int x;
        int p1;
        int p2;
        int p3;
        do_reset();
        p1 = 0;
        p2 = 0;
        p3 = 0;
        rand_bp = 1'b1;
        for (int i = 0; i < 200; i++) begin
            x = int'($urandom_range(0, 255));
            send(12'(4 * x + 3 * p1 + 2 * p2 + p3), 8'(x), 1'b0);
            p3 = p2;
            p2 = p1;
            p1 = x;
        end
        rand_bp = 1'b0;
        @(posedge CLK);
        #2;
        x_ready = 1'b1;
        drain("random");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_error();
        test_sat_low();
        test_sat_high();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_deconv8.md
Name: fir_deconv8

Overview:
- Inverse (deconvolution) stage for the team's 4-tap FIR filter y[n] = 4·x[n] + 3·x[n-1] + 2·x[n-2] + 1·x[n-3].
- Takes full-precision filtered samples and recursively recovers the original 8-bit samples.
- Sits at the receive end of the filter link and is used for round-trip checking of the filter datapath.
- Uses valid/ready streaming on both sides, a sticky consistency-error flag and an emitted-sample counter.

Parameters:
- DW, 8: width of recovered samples.
- YW, 12: width of filtered input samples. Must satisfy YW ≥ DW+4.
- CW, 16: width of the emitted-sample counter.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- y_valid  input  1  y_data is valid.
- y_ready  output  1  block accepts y_data this cycle.
- y_data  input  YW  unsigned filtered sample.
- x_valid  output  1  x_data is valid.
- x_ready  input  1  downstream accepts x_data.
- x_data  output  DW  recovered sample.
- clr_err  input  1  clears err_sticky.
- err  output  1  pulses for one cycle with the x_valid of the offending sample.
- err_sticky  output  1  latched error.
- sample_cnt  output  CW  count of emitted samples.

Behaviour:
- Reset values: x_valid=0, x_data=0, err=0, err_sticky=0, sample_cnt=0. History registers h1, h2, h3 (x[n-1], x[n-2], x[n-3]) = 0, matching the filter's post-reset state.
- y_ready = !x_valid || x_ready, combinational. It is low during reset.
- Accept occurs when y_valid && y_ready.
- On accept, compute signed residual r = y_data − 3·h1 − 2·h2 − h3 at width YW+3 bits, signed. Then q = r >>> 2 (arithmetic shift).
- Saturation and error conditions:
  - If r < 0: x_out = 0, error.
  - Else if q > 2^DW−1: x_out = 2^DW−1, error.
  - Else: x_out = q[DW-1:0]. If r[1:0] ≠ 0, this is also an error (non-multiple of 4).
- Registered on the accept edge: x_data ← x_out, x_valid ← 1, err ← error, h3←h2, h2←h1, h1←x_out. History always takes the emitted, saturated value.
- Latency: one cycle from accept to x_valid.
- Throughput: one sample per cycle when x_ready is held high.
- Output handshake:
  - Transfer occurs when x_valid && x_ready.
  - If transfer occurs with no new accept in the same cycle: x_valid←0, err←0.
  - A simultaneous transfer and accept reloads the output register with the new sample.
  - While x_valid && !x_ready: x_data and err hold stable and y_ready=0.
- sample_cnt increments on each output transfer and wraps from 2^CW−1 to 0.
- err_sticky:
  - Set on any accept with error.
  - Cleared by clr_err.
  - A set and clear in the same cycle resolves to set.
- A reset asserted mid-stream discards any pending output, zeroes history, counter and flags on the next edge, and ignores y_valid in that cycle.
- State machine:
  - EMPTY (x_valid=0): accept → FULL.
  - FULL:
    - transfer without accept → EMPTY
    - transfer with accept → FULL (new data)
    - otherwise hold.

Test Plan:
- Reset, then stream y = 40, 110, 200 with x_ready=1 → x_data = 10, 20, 30 on consecutive cycles, each one cycle after accept. err=0 throughout; sample_cnt=3.
- Reset, y=42 → x_data=10, err pulse=1, err_sticky=1. Pulse clr_err → err_sticky=0.
- Reset, y=4 then y=0 → x_data=1, then 0 (r=−3, saturated low) with err=1. History holds h1=0, h2=1.
- Reset, y=1024 → x_data=255, err=1. Next y=1020 gives r=1020−765=255 → x_data=63, err=1 (remainder 3).
- Backpressure: hold x_ready=0 after first output of the 40/110/200 stream → y_ready=0 and x_data stays 10 for 5 cycles. Release → 20, 30 follow with no sample loss or duplication.
- Assert reset while x_valid=1 mid-stream → next cycle x_valid=0, sample_cnt=0, err_sticky=0. Then y=40 → x_data=10, proving history cleared.
